serial_parity_framer: RTL and testbench
=======================================

Name: serial_parity_framer

Overview:
Parametrised serial parity unit, successor to the single-bit EVEN/ODD parity FSM. Processes fixed-length serial frames of DATA_BITS bits. Generate mode emits one parity bit per frame. Check mode consumes data plus a received parity bit and flags mismatches. Runtime odd/even selection, valid/ready handshake, frame abort and a frame counter. Sits between the serial shifter and the link framing logic.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 1..64.
CNT_W, $clog2(DATA_BITS+1), width of the bit counter.
FRAME_CNT_W, 16, width of the completed-frame counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
odd_sel  input  1  1 = odd parity, 0 = even; latched at first accepted bit of a frame
check_mode  input  1  0 = generate, 1 = check; latched with odd_sel
abort  input  1  synchronous frame discard
data_in  input  1  serial data bit
data_valid  input  1  data_in qualifier
data_ready  output  1  block can accept a bit this cycle
parity_bit  output  1  generated parity; meaningful when parity_valid=1
parity_valid  output  1  one-cycle pulse, generate mode
frame_done  output  1  one-cycle pulse at end of every completed frame (both modes)
parity_err  output  1  check result; meaningful when frame_done=1 and the latched mode was check
bit_cnt  output  CNT_W  bits accepted in the current frame
frame_cnt  output  FRAME_CNT_W  completed frames, wraps at 2^FRAME_CNT_W

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). Reset forces state=COLLECT, acc=0, bit_cnt=0, frame_cnt=0, latched mode/odd=0, data_ready=1, and parity_bit, parity_valid, frame_done, parity_err all 0.
- A bit is accepted when data_valid && data_ready. data_valid low cycles are gaps: no state change.
- Frame length: L = DATA_BITS (generate) or DATA_BITS+1 (check; the last bit is the received parity).
- State COLLECT: data_ready=1. Each accepted bit performs acc <= acc ^ data_in and bit_cnt <= bit_cnt+1. On the first accepted bit (bit_cnt==0), odd_sel and check_mode are latched; changes to them mid-frame are ignored.
- On acceptance of bit L-1 (0-based), go to DONE. Register the result: final = acc ^ data_in.
- State DONE: exactly one cycle, data_ready=0, frame_done=1, frame_cnt increments.
  - Generate mode: parity_valid=1, parity_bit = final ^ odd_latched. Odd parity makes the total count of ones odd: 0x00 -> 1.
  - Check mode: parity_err = (final != odd_latched).
  - Then go to COLLECT with acc=0 and bit_cnt=0.
- Total latency: parity/err is valid 1 cycle after the last bit is accepted. Back-to-back frames sustain L bits per L+1 cycles.
- parity_bit and parity_err hold their value until the next DONE. parity_valid and frame_done are pulses.
- abort=1 in COLLECT: acc and bit_cnt clear next cycle, no pulses, frame_cnt unchanged. If abort coincides with an accepted bit, abort wins and the bit is dropped. abort in DONE is ignored; the frame completes.
- Reset mid-frame or mid-DONE: immediate return to reset values, no pulse emitted.
- frame_cnt wraps from all-ones to 0 without a flag.
- DATA_BITS=1: generate frames are 1 bit, so DONE follows every accepted bit.

Decomposition:
- Package serial_parity_pkg holds:
  - state enum {COLLECT, DONE}
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1, MODE_GEN=1'b0, MODE_CHK=1'b1
- One sub-module, frame_bit_counter: parametrised CNT_W up-counter with clear, increment and terminal-count compare against a runtime limit (L-1). It is reused for both frame lengths.

Test Plan:
- DATA_BITS=8, odd, gen, bits of 0x00 back-to-back -> after 8th bit, next cycle parity_valid=1, parity_bit=1, frame_done=1, data_ready=0, frame_cnt=1.
- Even, gen, 0xFF then 0x01 with random data_valid gaps -> parity_bit=0 then 1; no pulses during gaps; frame_cnt=2.
- Odd, check, 0x07 + parity 0 -> parity_err=0. Same data + parity 1 -> parity_err=1. frame_done pulses each time.
- odd_sel toggled after bit 3 of a gen frame 0x03 latched odd -> parity_bit=1 (latched odd value used).
- abort asserted with the 5th bit -> bit_cnt=0 next cycle, no pulse; the next full 0x01 odd frame gives parity_bit=0.
- rst asserted asynchronously at bit 6 -> all outputs 0 and data_ready=1 immediately; frame_cnt=0; a subsequent frame behaves as from reset.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity framer.
package serial_parity_pkg;

  // COLLECT: shifting frame bits in; DONE: one-cycle result slot
  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Frame bit counter: up-counter with clear, increment and a terminal-count
// compare against a runtime limit, so one instance serves both frame lengths.
module frame_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  // Clear has priority so an abort or frame end never leaves a stale count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/serial_parity_framer.sv
// Serial parity framer: generates or checks one parity bit per frame of
// DATA_BITS serial bits, with runtime odd/even select, abort and frame count.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   COLLECT | accepting frame bits, folding them into the XOR accumulator
//   DONE    | one cycle: result pulses out, input stalled (data_ready=0)
module serial_parity_framer
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int CNT_W       = $clog2(DATA_BITS + 1),
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   odd_sel,
  input  logic                   check_mode,
  input  logic                   abort,
  input  logic                   data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   parity_bit,
  output logic                   parity_valid,
  output logic                   frame_done,
  output logic                   parity_err,
  output logic [CNT_W-1:0]       bit_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // Terminal counts: last data bit (generate) or received parity bit (check).
  localparam logic [CNT_W-1:0] LIM_GEN = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LIM_CHK = CNT_W'(DATA_BITS);

  state_t           state_q, state_d;
  logic             acc;
  logic             odd_lat, chk_lat;
  logic             accept, first_bit, last_bit, at_limit;
  logic             mode_eff, odd_eff, fin_par, do_abort, cnt_clr;
  logic [CNT_W-1:0] limit;

  // Abort outranks an accepted bit; DONE never accepts, so abort there is moot.
  assign do_abort  = (state_q == COLLECT) && abort;
  assign accept    = (state_q == COLLECT) && data_valid && !abort;
  assign first_bit = (bit_cnt == '0);

  // On the first bit the latches are only being loaded, so use the live inputs;
  // this matters when the frame is a single bit long.
  assign mode_eff = first_bit ? check_mode : chk_lat;
  assign odd_eff  = first_bit ? odd_sel    : odd_lat;
  assign limit    = (mode_eff == MODE_CHK) ? LIM_CHK : LIM_GEN;
  assign last_bit = accept && at_limit;
  assign fin_par  = acc ^ data_in;
  assign cnt_clr  = do_abort || last_bit;

  frame_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (accept),
    .limit    (limit),
    .cnt      (bit_cnt),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/pulse outputs.
  always_comb begin
    state_d      = state_q;
    data_ready   = 1'b0;
    parity_valid = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      COLLECT: begin
        data_ready = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_done   = 1'b1;
        parity_valid = (chk_lat == MODE_GEN);
        state_d      = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Accumulator, mode latches, held results and frame counter. Results are
  // registered on the last bit so they are visible during DONE and held after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= 1'b0;
      odd_lat    <= PAR_EVEN;
      chk_lat    <= MODE_GEN;
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
      frame_cnt  <= '0;
    end else if (do_abort) begin
      acc <= 1'b0;
    end else if (accept) begin
      if (first_bit) begin
        odd_lat <= odd_sel;
        chk_lat <= check_mode;
      end
      if (last_bit) begin
        acc       <= 1'b0;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        if (mode_eff == MODE_CHK) begin
          parity_err <= (fin_par != odd_eff);
        end else begin
          parity_bit <= fin_par ^ odd_eff;
        end
      end else begin
        acc <= fin_par;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Self-checking bench for serial_parity_framer with DATA_BITS=8.
module tb_serial_parity_framer;

  localparam int DATA_BITS   = 8;
  localparam int CNT_W       = $clog2(DATA_BITS + 1);
  localparam int FRAME_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   odd_sel, check_mode, abort, data_in, data_valid;
  logic                   data_ready, parity_bit, parity_valid, frame_done, parity_err;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [FRAME_CNT_W-1:0] model_cnt;

  logic o_pv, o_pb, o_fd, o_pe, o_dr;
  logic [FRAME_CNT_W-1:0] o_fc;
  int   o_spur, o_done_cyc;

  serial_parity_framer #(
    .DATA_BITS   (DATA_BITS),
    .CNT_W       (CNT_W),
    .FRAME_CNT_W (FRAME_CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .odd_sel      (odd_sel),
    .check_mode   (check_mode),
    .abort        (abort),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .parity_bit   (parity_bit),
    .parity_valid (parity_valid),
    .frame_done   (frame_done),
    .parity_err   (parity_err),
    .bit_cnt      (bit_cnt),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: parity bit that makes data ones + parity bit odd (odd=1) or even.
  function automatic logic ref_gen(input logic [7:0] d, input logic odd);
    int ones = $countones(d);
    return ((ones + int'(odd)) % 2) == 1;
  endfunction

  // Reference: error when the total ones count has the wrong parity.
  function automatic logic ref_err(input logic [7:0] d, input logic rx, input logic odd);
    int total = $countones(d) + int'(rx);
    return (total % 2) != int'(odd);
  endfunction

  // Drives nbits serial bits with optional random gaps; optionally flips the
  // mode inputs just before bit flip_at. Captures outputs one cycle after the
  // last bit, i.e. in the result cycle.
  task automatic send_frame(input logic [63:0] bits, input int nbits,
                            input int max_gap, input int flip_at);
    o_spur = 0;
    for (int i = 0; i < nbits; i++) begin
      int gap;
      int w;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        if (frame_done || parity_valid) o_spur++;
      end
      @(negedge clk);
      if (i == flip_at) begin
        odd_sel    = ~odd_sel;
        check_mode = ~check_mode;
      end
      w = 0;
      while (!data_ready && w < 20) begin
        data_valid = 1'b0;
        @(negedge clk);
        w++;
      end
      if (w >= 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: data_ready still %0b after %0d cycles, required 1", data_ready, w);
      end
      data_valid = 1'b1;
      data_in    = bits[i];
      @(posedge clk);
      #1;
      if (i < nbits - 1 && (frame_done || parity_valid)) o_spur++;
    end
    o_pv       = parity_valid;
    o_pb       = parity_bit;
    o_fd       = frame_done;
    o_pe       = parity_err;
    o_dr       = data_ready;
    o_fc       = frame_cnt;
    o_done_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    data_valid = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; odd_sel = 1'b0; check_mode = 1'b0; abort = 1'b0;
    data_in = 1'b0; data_valid = 1'b0;
    model_cnt = '0;
    #12;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", data_ready); end
    checks++; if (parity_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %0b want 0", parity_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone: got %0b want 0", frame_done); end
    checks++; if (parity_bit !== 1'b0) begin errors++; $display("FAIL reset_pbit: got %0b want 0", parity_bit); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b want 0", parity_err); end
    checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_framecnt: got %0d want 0", frame_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gen_back_to_back();
    int first_done;
    odd_sel = 1'b1; check_mode = 1'b0;
    send_frame(64'h00, DATA_BITS, 0, -1);
    model_cnt++;
    first_done = o_done_cyc;
    checks++; if (o_pv !== 1'b1) begin errors++; $display("FAIL b2b_pvalid: got %0b want 1", o_pv); end
    checks++; if (o_pb !== ref_gen(8'h00, 1'b1)) begin errors++; $display("FAIL b2b_pbit: got %0b want %0b", o_pb, ref_gen(8'h00, 1'b1)); end
    checks++; if (o_fd !== 1'b1) begin errors++; $display("FAIL b2b_fdone: got %0b want 1", o_fd); end
    checks++; if (o_dr !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %0b want 0", o_dr); end
    checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL b2b_framecnt: got %0d want %0d", o_fc, model_cnt); end
    send_frame(64'h00, DATA_BITS, 0, -1);
    model_cnt++;
    checks++; if (o_done_cyc - first_done !== DATA_BITS + 1) begin errors++; $display("FAIL b2b_throughput: got %0d cycles want %0d", o_done_cyc - first_done, DATA_BITS + 1); end
    checks++; if (o_spur !== 0) begin errors++; $display("FAIL b2b_spurious: got %0d pulses want 0", o_spur); end
    checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL b2b_framecnt2: got %0d want %0d", o_fc, model_cnt); end
    idle();
  endtask

  task automatic test_gen_gaps();
    logic [7:0] pat [2];
    pat[0] = 8'hFF; pat[1] = 8'h01;
    odd_sel = 1'b0; check_mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_frame({56'h0, pat[k]}, DATA_BITS, 3, -1);
      model_cnt++;
      checks++; if (o_pb !== ref_gen(pat[k], 1'b0)) begin errors++; $display("FAIL gaps_pbit%0d: got %0b want %0b", k, o_pb, ref_gen(pat[k], 1'b0)); end
      checks++; if (o_pv !== 1'b1 || o_fd !== 1'b1) begin errors++; $display("FAIL gaps_pulse%0d: got pv=%0b fd=%0b want 1/1", k, o_pv, o_fd); end
      checks++; if (o_spur !== 0) begin errors++; $display("FAIL gaps_spurious%0d: got %0d want 0", k, o_spur); end
      checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL gaps_framecnt%0d: got %0d want %0d", k, o_fc, model_cnt); end
    end
    idle();
  endtask

  task automatic test_check();
    logic rx;
    odd_sel = 1'b1; check_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rx = (k == 1);
      send_frame({55'h0, rx, 8'h07}, DATA_BITS + 1, 1, -1);
      model_cnt++;
      checks++; if (o_pe !== ref_err(8'h07, rx, 1'b1)) begin errors++; $display("FAIL check_err%0d: got %0b want %0b", k, o_pe, ref_err(8'h07, rx, 1'b1)); end
      checks++; if (o_fd !== 1'b1 || o_pv !== 1'b0) begin errors++; $display("FAIL check_pulse%0d: got fd=%0b pv=%0b want 1/0", k, o_fd, o_pv); end
      checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL check_framecnt%0d: got %0d want %0d", k, o_fc, model_cnt); end
    end
    idle();
    checks++; if (parity_err !== ref_err(8'h07, 1'b1, 1'b1)) begin errors++; $display("FAIL check_hold: got %0b want %0b", parity_err, ref_err(8'h07, 1'b1, 1'b1)); end
  endtask

  task automatic test_latch();
    odd_sel = 1'b1; check_mode = 1'b0;
    send_frame(64'h03, DATA_BITS, 0, 3);
    model_cnt++;
    checks++; if (o_pb !== ref_gen(8'h03, 1'b1)) begin errors++; $display("FAIL latch_pbit: got %0b want %0b", o_pb, ref_gen(8'h03, 1'b1)); end
    checks++; if (o_pv !== 1'b1) begin errors++; $display("FAIL latch_pvalid: got %0b want 1", o_pv); end
    checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL latch_framecnt: got %0d want %0d", o_fc, model_cnt); end
    idle();
  endtask

  task automatic test_abort();
    logic [7:0] junk;
    junk = 8'($urandom);
    odd_sel = 1'b1; check_mode = 1'b0;
    send_frame({56'h0, junk}, 4, 0, -1);
    checks++; if (bit_cnt !== CNT_W'(4)) begin errors++; $display("FAIL abort_precnt: got %0d want 4", bit_cnt); end
    @(negedge clk);
    data_valid = 1'b1; data_in = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL abort_bitcnt: got %0d want 0", bit_cnt); end
    checks++; if (frame_done !== 1'b0 || parity_valid !== 1'b0) begin errors++; $display("FAIL abort_pulse: got fd=%0b pv=%0b want 0/0", frame_done, parity_valid); end
    checks++; if (frame_cnt !== model_cnt) begin errors++; $display("FAIL abort_framecnt: got %0d want %0d", frame_cnt, model_cnt); end
    idle();
    send_frame(64'h01, DATA_BITS, 0, -1);
    model_cnt++;
    checks++; if (o_pb !== ref_gen(8'h01, 1'b1)) begin errors++; $display("FAIL abort_next_pbit: got %0b want %0b", o_pb, ref_gen(8'h01, 1'b1)); end
    checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL abort_next_framecnt: got %0d want %0d", o_fc, model_cnt); end
    idle();
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    odd_sel = 1'b1; check_mode = 1'b0;
    send_frame(64'hA5, 6, 0, -1);
    #2;
    rst = 1'b1;
    #1;
    model_cnt = '0;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", data_ready); end
    checks++; if (bit_cnt !== '0 || frame_cnt !== '0) begin errors++; $display("FAIL rst_counts: got bit=%0d frame=%0d want 0/0", bit_cnt, frame_cnt); end
    checks++; if ({parity_bit, parity_valid, frame_done, parity_err} !== 4'b0) begin errors++; $display("FAIL rst_outputs: got %b want 0000", {parity_bit, parity_valid, frame_done, parity_err}); end
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    d = 8'($urandom);
    odd_sel = 1'b0;
    send_frame({56'h0, d}, DATA_BITS, 0, -1);
    model_cnt++;
    checks++; if (o_pb !== ref_gen(d, 1'b0)) begin errors++; $display("FAIL rst_next_pbit: data %02h got %0b want %0b", d, o_pb, ref_gen(d, 1'b0)); end
    checks++; if (o_fc !== model_cnt) begin errors++; $display("FAIL rst_next_framecnt: got %0d want %0d", o_fc, model_cnt); end
    idle();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic odd, chk, rx;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom); odd = 1'($urandom); chk = 1'($urandom); rx = 1'($urandom);
      odd_sel = odd; check_mode = chk;
      send_frame({55'h0, rx, d}, chk ? DATA_BITS + 1 : DATA_BITS, 2, -1);
      model_cnt++;
      if (chk) begin
        checks++; if (o_pe !== ref_err(d, rx, odd)) begin errors++; $display("FAIL rand_err%0d: d=%02h rx=%0b odd=%0b got %0b want %0b", k, d, rx, odd, o_pe, ref_err(d, rx, odd)); end
      end else begin
        checks++; if (o_pb !== ref_gen(d, odd)) begin errors++; $display("FAIL rand_pbit%0d: d=%02h odd=%0b got %0b want %0b", k, d, odd, o_pb, ref_gen(d, odd)); end
      end
      checks++; if (o_fd !== 1'b1 || o_pv !== !chk) begin errors++; $display("FAIL rand_pulse%0d: got fd=%0b pv=%0b want 1/%0b", k, o_fd, o_pv, !chk); end
      checks++; if (o_fc !== model_cnt || o_spur !== 0) begin errors++; $display("FAIL rand_cnt%0d: got frame=%0d spur=%0d want %0d/0", k, o_fc, o_spur, model_cnt); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_gen_back_to_back();
    test_gen_gaps();
    test_check();
    test_latch();
    test_abort();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
